// File: rtl/eth_rx_axi_reader.sv
// AXI read initiator draining received Ethernet frames into a 32-bit valid/ready word stream.
// Optional protocol-type read is compiled in when ETH_RX_PROTO_READ_EN is defined.
`timescale 1ns/1ps
module eth_rx_axi_reader #(
  parameter logic [31:0] ADDR_RX_DATA_COUNT    = 32'h0000_0010,
  parameter logic [31:0] ADDR_RX_DATA          = 32'h0000_0008,
  parameter logic [31:0] ADDR_RX_PROTOCOL_TYPE = 32'h0000_0014,
  parameter logic [15:0] MAX_WORDS             = 16'd400,
  parameter logic [15:0] TIMEOUT_CYCLES        = 16'd4095
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_ready_int,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] pkt_len,
`ifdef ETH_RX_PROTO_READ_EN
  output logic [15:0] pkt_proto,
`endif
  output logic        pkt_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_AR_CNT,
    S_R_CNT,
`ifdef ETH_RX_PROTO_READ_EN
    S_AR_PROTO,
    S_R_PROTO,
`endif
    S_AR_DATA,
    S_R_DATA,
    S_DRAIN,
    S_WAIT_CLR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic        pkt_err_q, pkt_err_d;
`ifdef ETH_RX_PROTO_READ_EN
  logic [15:0] pkt_proto_q, pkt_proto_d;
`endif
  logic        abort;
  logic        ar_hs, r_hs, out_hs;

  assign abort = (state_q != S_IDLE) && (timer_q >= TIMEOUT_CYCLES);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    timer_d   = timer_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    pkt_len_d = pkt_len_q;
    pkt_err_d = 1'b0;
`ifdef ETH_RX_PROTO_READ_EN
    pkt_proto_d = pkt_proto_q;
`endif
    araddr  = 32'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    out_hs  = m_valid_q && m_ready;

    if (out_hs) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        beat_d = 16'd0;
        if (enable && rx_ready_int) state_d = S_AR_CNT;
      end
      S_AR_CNT: begin
        araddr  = ADDR_RX_DATA_COUNT;
        arvalid = !abort;
        if (arvalid && arready) state_d = S_R_CNT;
      end
      S_R_CNT: begin
        rready = !abort;
        if (rready && rvalid) begin
          pkt_len_d = rdata[15:0];
          // The slave discards 1FFF-count frames on its own, so skip the data read.
          if (rdata[15:0] == 16'h1FFF) state_d = S_WAIT_CLR;
`ifdef ETH_RX_PROTO_READ_EN
          else                         state_d = S_AR_PROTO;
`else
          else                         state_d = S_AR_DATA;
`endif
        end
      end
`ifdef ETH_RX_PROTO_READ_EN
      S_AR_PROTO: begin
        araddr  = ADDR_RX_PROTOCOL_TYPE;
        arvalid = !abort;
        if (arvalid && arready) state_d = S_R_PROTO;
      end
      S_R_PROTO: begin
        rready = !abort;
        if (rready && rvalid) begin
          pkt_proto_d = rdata[15:0];
          state_d     = S_AR_DATA;
        end
      end
`endif
      S_AR_DATA: begin
        araddr  = ADDR_RX_DATA;
        arvalid = !abort;
        if (arvalid && arready) state_d = S_R_DATA;
      end
      S_R_DATA: begin
        // One-entry output register: accept a beat whenever it is empty or emptying.
        rready = !abort && (!m_valid_q || m_ready);
        if (rready && rvalid) begin
          m_data_d  = rdata;
          m_valid_d = 1'b1;
          m_last_d  = rlast;
          beat_d    = beat_q + 16'd1;
          if (rlast) begin
            state_d = S_WAIT_CLR;
          end else if (beat_q + 16'd1 == MAX_WORDS) begin
            pkt_err_d = 1'b1;
            m_last_d  = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        rready = !abort;
        if (rready && rvalid && rlast) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!rx_ready_int) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ar_hs = arvalid && arready;
    r_hs  = rready && rvalid;
    if (state_q == S_IDLE || state_d != state_q || ar_hs || r_hs || out_hs)
      timer_d = 16'd0;
    else
      timer_d = timer_q + 16'd1;

    // A word still waiting in the output register is delivered, but closes the frame.
    if (abort) begin
      pkt_err_d = 1'b1;
      state_d   = S_IDLE;
      timer_d   = 16'd0;
      if (m_valid_q && !m_ready) m_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100_mhz) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= 16'd0;
      timer_q   <= 16'd0;
      m_data_q  <= 32'h0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      pkt_len_q <= 16'd0;
      pkt_err_q <= 1'b0;
`ifdef ETH_RX_PROTO_READ_EN
      pkt_proto_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      timer_q   <= timer_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      pkt_len_q <= pkt_len_d;
      pkt_err_q <= pkt_err_d;
`ifdef ETH_RX_PROTO_READ_EN
      pkt_proto_q <= pkt_proto_d;
`endif
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign pkt_len = pkt_len_q;
  assign pkt_err = pkt_err_q;
  assign busy    = (state_q != S_IDLE);
`ifdef ETH_RX_PROTO_READ_EN
  assign pkt_proto = pkt_proto_q;
`endif

endmodule
